ps2_key_decoder: RTL and testbench

- Front end of the keyboard path. Deserialises PS/2 device-to-host frames and tracks the E0 (extended) and F0 (break) prefixes.
- Outputs the key event interface the game logic consumes: key_down bitmap, last_change, key_valid.
- Sits between the board PS/2 pins and the counting/typing logic; drives its key_down, last_change and key_valid inputs directly.

---
 rtl/ps2_key_decoder_if.sv | 23 ++
 rtl/ps2_key_decoder.sv | 179 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// Key event bus between the PS/2 decoder and its consumer: raw PS/2 pins and flush in, key events out.
interface ps2_key_decoder_if #(
    parameter int KEY_W = 128
);
    logic             ps2_clk;
    logic             ps2_data;
    logic             flush;
    logic [KEY_W-1:0] key_down;
    logic [8:0]       last_change;
    logic             key_valid;
    logic             frame_err;

    // master drives the pins and flush; slave is the decoder producing key events
    modport master (
        output ps2_clk, ps2_data, flush,
        input  key_down, last_change, key_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, flush,
        output key_down, last_change, key_valid, frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host receiver with E0/F0 prefix tracking and a held-key bitmap.
// Optional macro PS2_PARITY_CHECK_EN turns on odd-parity checking of each received byte.
module ps2_key_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int KEY_W          = 128
) (
    input logic              clk,
    input logic              rst_n,
    ps2_key_decoder_if.slave bus
);
    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int              IDX_W  = $clog2(KEY_W);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    rx_state_t        state;
    rx_state_t        state_next;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic             clk_prev;
    logic             fall;
    logic             data_bit;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [CNT_W-1:0] to_cnt;
    logic             timeout;
    logic             shift_en;
    logic             frame_done;
    logic             parity_ok;
    logic             byte_ok;
    logic             byte_valid;
    logic             ext;
    logic             brk;
    logic [IDX_W-1:0] key_idx;
    logic [KEY_W-1:0] key_down;
    logic [8:0]       last_change;
    logic             key_valid;
    logic             frame_err;

    // Idle-high reset values keep the synchroniser from inventing a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_bit = data_sync[SYNC_STAGES-1];
    assign timeout  = (state != IDLE) && !fall && (to_cnt == TO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (fall || state == IDLE) begin
            to_cnt <= '0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_bit) state_next = DATA;
                DATA:    if (bit_idx == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_en   = 1'b0;
        frame_done = 1'b0;
        if (fall) begin
            shift_en   = (state == DATA);
            frame_done = (state == STOP);
        end
    end

    // bit_idx wraps 7->0 on its own after a full byte; IDLE also clears it after a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
        end else if (shift_en) begin
            shift_reg <= {data_bit, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
        end else if (state == IDLE) begin
            bit_idx   <= 3'd0;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit <= 1'b0;
        end else if (fall && state == PARITY) begin
            parity_bit <= data_bit;
        end
    end

    assign parity_ok = ^{shift_reg, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    assign byte_ok = data_bit && parity_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= frame_done && byte_ok;
            frame_err  <= frame_done && !byte_ok;
        end
    end

    assign key_idx = IDX_W'(shift_reg);

    // shift_reg stays stable until the next frame's data bits, so decode reads it directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_down    <= '0;
            last_change <= 9'd0;
            key_valid   <= 1'b0;
            ext         <= 1'b0;
            brk         <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (byte_valid) begin
                if (shift_reg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    last_change <= {ext, shift_reg};
                    key_valid   <= 1'b1;
                    ext         <= 1'b0;
                    brk         <= 1'b0;
                    if (!ext && (32'(shift_reg) < KEY_W)) begin
                        key_down[key_idx] <= ~brk;
                    end
                end
            end
            if (bus.flush) begin
                key_down <= '0;
            end
        end
    end

    assign bus.key_down    = key_down;
    assign bus.last_change = last_change;
    assign bus.key_valid   = key_valid;
    assign bus.frame_err   = frame_err;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed frame scenarios plus a random key-event stream.
module tb_ps2_key_decoder;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int KEY_W          = 128;
    localparam int HALF           = 8;
    localparam int GAP            = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ps2_key_decoder_if #(.KEY_W(KEY_W)) bus ();

    ps2_key_decoder #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .KEY_W         (KEY_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int               total = 0;
    int               bad   = 0;
    logic [8:0]       ev_q[$];
    int               err_cnt = 0;
    logic [KEY_W-1:0] model_down = '0;
    logic [8:0]       got0;
    logic [8:0]       got1;

    // Event recorder: every key_valid pulse and frame_err pulse seen by the consumer
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.key_valid) ev_q.push_back(bus.last_change);
            if (bus.frame_err) err_cnt++;
        end
    end

    task automatic clear_obs();
        ev_q.delete();
        err_cnt = 0;
    endtask

    task automatic drive_bit(input logic b);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(~(^b) ^ bad_par);
        drive_bit(~bad_stop);
        bus.ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits);
        drive_bit(1'b0);
        for (int i = 1; i < nbits; i++) drive_bit(1'($urandom_range(0, 1)));
        bus.ps2_data = 1'b1;
    endtask

    // Key-level model: one key event becomes its prefix/code byte sequence
    task automatic key_event(input logic [7:0] code, input logic is_ext, input logic make);
        if (is_ext) send_frame(8'hE0, 1'b0, 1'b0);
        if (!make) send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(code, 1'b0, 1'b0);
        if (!is_ext && code < KEY_W) model_down[code] = make;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.key_down !== '0) begin bad++; $display("[TB] FAIL reset_key_down got=%h exp=0", bus.key_down); end
        total++; if (bus.last_change !== 9'd0) begin bad++; $display("[TB] FAIL reset_last_change got=%h exp=0", bus.last_change); end
        total++; if (bus.key_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_key_valid got=%b exp=0", bus.key_valid); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_make();
        clear_obs();
        key_event(8'h1C, 1'b0, 1'b1);
        got0 = (ev_q.size() > 0) ? ev_q[0] : 9'bx;
        total++; if (ev_q.size() != 1 || got0 !== 9'h01C) begin bad++; $display("[TB] FAIL make_event count=%0d got=%h exp=1x01c", ev_q.size(), got0); end
        total++; if (bus.key_down !== (128'd1 << 28)) begin bad++; $display("[TB] FAIL make_key_down got=%h exp=%h", bus.key_down, 128'd1 << 28); end
    endtask

    task automatic test_break();
        clear_obs();
        key_event(8'h1C, 1'b0, 1'b0);
        got0 = (ev_q.size() > 0) ? ev_q[0] : 9'bx;
        total++; if (ev_q.size() != 1 || got0 !== 9'h01C) begin bad++; $display("[TB] FAIL break_event count=%0d got=%h exp=1x01c", ev_q.size(), got0); end
        total++; if (bus.key_down !== '0) begin bad++; $display("[TB] FAIL break_key_down got=%h exp=0", bus.key_down); end
    endtask

    task automatic test_extended();
        clear_obs();
        key_event(8'h75, 1'b1, 1'b1);
        key_event(8'h75, 1'b1, 1'b0);
        got0 = (ev_q.size() > 0) ? ev_q[0] : 9'bx;
        got1 = (ev_q.size() > 1) ? ev_q[1] : 9'bx;
        total++; if (ev_q.size() != 2 || got0 !== 9'h175 || got1 !== 9'h175) begin bad++; $display("[TB] FAIL ext_events count=%0d got=%h,%h exp=2x175", ev_q.size(), got0, got1); end
        total++; if (bus.key_down !== '0) begin bad++; $display("[TB] FAIL ext_key_down got=%h exp=0", bus.key_down); end
    endtask

    task automatic test_frame_errors();
        clear_obs();
        send_frame(8'h29, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        total++; if (ev_q.size() != 0 || err_cnt != 1) begin bad++; $display("[TB] FAIL parity_drop events=%0d errs=%0d exp=0,1", ev_q.size(), err_cnt); end
        total++; if (bus.key_down[41] !== 1'b0) begin bad++; $display("[TB] FAIL parity_key41 got=%b exp=0", bus.key_down[41]); end
`else
        got0 = (ev_q.size() > 0) ? ev_q[0] : 9'bx;
        total++; if (ev_q.size() != 1 || got0 !== 9'h029 || err_cnt != 0) begin bad++; $display("[TB] FAIL parity_ignored events=%0d got=%h errs=%0d exp=1,029,0", ev_q.size(), got0, err_cnt); end
        total++; if (bus.key_down[41] !== 1'b1) begin bad++; $display("[TB] FAIL parity_key41 got=%b exp=1", bus.key_down[41]); end
`endif
        clear_obs();
        send_frame(8'h29, 1'b0, 1'b0);
        model_down[41] = 1'b1;
        total++; if (bus.key_down !== model_down || err_cnt != 0) begin bad++; $display("[TB] FAIL good_29 key_down=%h exp=%h errs=%0d", bus.key_down, model_down, err_cnt); end
        clear_obs();
        send_frame(8'h33, 1'b0, 1'b1);
        total++; if (ev_q.size() != 0 || err_cnt != 1 || bus.key_down !== model_down) begin bad++; $display("[TB] FAIL stop_drop events=%0d errs=%0d key_down=%h exp=0,1,%h", ev_q.size(), err_cnt, bus.key_down, model_down); end
    endtask

    task automatic test_timeout();
        clear_obs();
        send_partial(5);
        repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
        send_frame(8'h66, 1'b0, 1'b0);
        model_down[102] = 1'b1;
        got0 = (ev_q.size() > 0) ? ev_q[0] : 9'bx;
        total++; if (ev_q.size() != 1 || got0 !== 9'h066) begin bad++; $display("[TB] FAIL timeout_event count=%0d got=%h exp=1x066", ev_q.size(), got0); end
        total++; if (bus.key_down !== model_down || err_cnt != 0) begin bad++; $display("[TB] FAIL timeout_state key_down=%h exp=%h errs=%0d", bus.key_down, model_down, err_cnt); end
    endtask

    task automatic test_flush();
        key_event(8'h1C, 1'b0, 1'b1);
        total++; if (bus.key_down !== model_down || model_down[28] !== 1'b1 || model_down[41] !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre key_down=%h exp=%h", bus.key_down, model_down); end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_down = '0;
        total++; if (bus.key_down !== '0) begin bad++; $display("[TB] FAIL flush_clear got=%h exp=0", bus.key_down); end
    endtask

    task automatic test_reset_mid_frame();
        key_event(8'h1C, 1'b0, 1'b1);
        send_partial(5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (bus.key_down !== '0 || bus.last_change !== 9'd0 || bus.key_valid !== 1'b0 || bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid outputs kd=%h lc=%h kv=%b fe=%b exp=all 0", bus.key_down, bus.last_change, bus.key_valid, bus.frame_err); end
        model_down = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        clear_obs();
        key_event(8'h5A, 1'b0, 1'b1);
        got0 = (ev_q.size() > 0) ? ev_q[0] : 9'bx;
        total++; if (ev_q.size() != 1 || got0 !== 9'h05A || bus.key_down !== model_down) begin bad++; $display("[TB] FAIL rst_after count=%0d got=%h kd=%h exp=1x05a kd=%h", ev_q.size(), got0, bus.key_down, model_down); end
    endtask

    task automatic test_random_events();
        logic [7:0] code;
        logic       is_ext;
        logic       make;
        for (int n = 0; n < 30; n++) begin
            code = 8'($urandom_range(0, 255));
            while (code == 8'hE0 || code == 8'hF0) code = 8'($urandom_range(0, 255));
            if (n % 3 == 0) code = 8'($urandom_range(0, 7));
            is_ext = ($urandom_range(0, 3) == 0);
            make   = ($urandom_range(0, 2) != 0);
            clear_obs();
            key_event(code, is_ext, make);
            got0 = (ev_q.size() > 0) ? ev_q[0] : 9'bx;
            total++; if (ev_q.size() != 1 || got0 !== {is_ext, code}) begin bad++; $display("[TB] FAIL rand_event n=%0d count=%0d got=%h exp=%h", n, ev_q.size(), got0, {is_ext, code}); end
            total++; if (bus.key_down !== model_down) begin bad++; $display("[TB] FAIL rand_key_down n=%0d got=%h exp=%h", n, bus.key_down, model_down); end
        end
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        bus.flush    = 1'b0;
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_frame_errors();
        test_timeout();
        test_flush();
        test_reset_mid_frame();
        test_random_events();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
